// File: rtl/spi_sram_pkg.sv
// Shared constants, FSM encoding and frame builder for the SPI SRAM master.
// A frame is opcode, 16-bit address, then one data byte, sent MSB first.
package spi_sram_pkg;

  localparam logic [7:0] SPI_CMD_READ       = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE      = 8'h02;
  localparam int unsigned SPI_FRAME_BITS    = 32;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } spi_state_e;

  // Read frames carry a zero data byte; the SRAM drives MISO during that byte instead.
  function automatic logic [SPI_FRAME_BITS-1:0] spi_frame(input logic        we,
                                                         input logic [15:0] addr,
                                                         input logic [7:0]  wdata);
    return {(we ? SPI_CMD_WRITE : SPI_CMD_READ), addr, (we ? wdata : 8'h00)};
  endfunction

endpackage

// File: rtl/spi_sram_master_sclk_gen.sv
// SPI clock divider: registered sclk, idle low, plus strobes flagging the edge on which sclk
// will rise or fall. Disabling it parks sclk low and restarts the low phase.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sclk_q, sclk_d;
  logic            tick;

  assign tick      = en && (cnt_q == CntW'(CLK_DIV - 1));
  assign rise_tick = tick && !sclk_q;
  assign fall_tick = tick && sclk_q;
  assign sclk      = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (tick) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_sram_master.sv
// CPU-side SPI mode-0 master turning single-byte read/write requests into 23LC-style
// SRAM frames (opcode, 16-bit address, data byte).
module spi_sram_master
  import spi_sram_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned CS_IDLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        busy
);

  localparam int unsigned BitW = $clog2(SPI_FRAME_BITS);
  localparam int unsigned GapW = (CS_IDLE > 2) ? $clog2(CS_IDLE) : 1;

  spi_state_e                state_q, state_d;
  logic [SPI_FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [7:0]                rx_q, rx_d;
  logic [BitW-1:0]           bit_q, bit_d;
  logic [GapW-1:0]           gap_q, gap_d;
  logic                      we_q, we_d;
  logic                      cs_n_q, cs_n_d;
  logic                      ready_q, ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [7:0]                rdata_q, rdata_d;

  logic sclk_en;
  logic rise_tick;
  logic fall_tick;

  // The first SHIFT cycle only drops cs_n; the divider starts once cs_n is low.
  assign sclk_en = (state_q == StShift) && !cs_n_q;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (sclk_en),
    .sclk      (spi_sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    rx_d        = rx_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    we_d        = we_q;
    cs_n_d      = cs_n_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && ready_q) begin
          state_d = StShift;
          shreg_d = spi_frame(req_we, req_addr, req_wdata);
          we_d    = req_we;
          bit_d   = '0;
          rx_d    = '0;
        end
      end
      StShift: begin
        if (cs_n_q) begin
          cs_n_d = 1'b0;
        end
        // Only the data byte carries read data; earlier MISO bits are don't-care.
        if (rise_tick && (bit_q >= BitW'(24))) begin
          rx_d = {rx_q[6:0], spi_miso};
        end
        if (fall_tick) begin
          if (bit_q == BitW'(SPI_FRAME_BITS - 1)) begin
            state_d     = (CS_IDLE > 1) ? StGap : StIdle;
            cs_n_d      = 1'b1;
            shreg_d     = '0;
            gap_d       = '0;
            rsp_valid_d = 1'b1;
            if (!we_q) begin
              rdata_d = rx_q;
            end
          end else begin
            shreg_d = {shreg_q[SPI_FRAME_BITS-2:0], 1'b0};
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      StGap: begin
        // cs_n already spent the completion cycle high, so GAP lasts CS_IDLE-1 cycles.
        if (gap_q == GapW'(CS_IDLE - 2)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered so it stays low until the first clock edge after reset release.
  assign ready_d = (state_d == StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      rx_q        <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      we_q        <= 1'b0;
      cs_n_q      <= 1'b1;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      rx_q        <= rx_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      we_q        <= we_d;
      cs_n_q      <= cs_n_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = ~ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = shreg_q[SPI_FRAME_BITS-1];

endmodule

// File: tb/tb_spi_sram_master.sv
// Bench for spi_sram_master: two instances (CLK_DIV=1 and 3) share a behavioural 23LC SRAM
// and a response scoreboard keyed on the expected completion cycle.
module tb_spi_sram_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid1, req_valid3, req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        ready1, ready3, rsp_valid1, rsp_valid3, busy1, busy3;
  logic [7:0]  rdata1, rdata3;
  logic        cs1, cs3, sclk1, sclk3, mosi1, mosi3;
  logic        m_miso;
  logic        sel3;

  spi_sram_master #(.CLK_DIV(1), .CS_IDLE(2)) dut1 (
    .clk (clk), .reset (reset), .req_valid (req_valid1), .req_ready (ready1), .req_we (req_we),
    .req_addr (req_addr), .req_wdata (req_wdata), .rsp_valid (rsp_valid1), .rsp_rdata (rdata1),
    .spi_cs_n (cs1), .spi_sclk (sclk1), .spi_mosi (mosi1), .spi_miso (m_miso), .busy (busy1)
  );

  spi_sram_master #(.CLK_DIV(3), .CS_IDLE(2)) dut3 (
    .clk (clk), .reset (reset), .req_valid (req_valid3), .req_ready (ready3), .req_we (req_we),
    .req_addr (req_addr), .req_wdata (req_wdata), .rsp_valid (rsp_valid3), .rsp_rdata (rdata3),
    .spi_cs_n (cs3), .spi_sclk (sclk3), .spi_mosi (mosi3), .spi_miso (m_miso), .busy (busy3)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model, mode 0: sample MOSI on rising sclk, drive MISO after falling sclk.
  logic        m_cs_n, m_sclk, m_mosi;
  logic [7:0]  mem [0:65535];
  int unsigned m_bits = 0;
  logic [31:0] m_frame;
  logic [7:0]  m_op, m_rd;
  logic [15:0] m_addr;
  int unsigned m_last_bits = 0;
  logic [31:0] m_last_frame;
  time         m_rise_t [2];

  assign m_cs_n = sel3 ? cs3 : cs1;
  assign m_sclk = sel3 ? sclk3 : sclk1;
  assign m_mosi = sel3 ? mosi3 : mosi1;

  always @(negedge m_cs_n) begin
    m_bits  = 0;
    m_frame = '0;
    m_miso  = 1'b0;
  end

  always @(posedge m_sclk) begin
    if (!m_cs_n) begin
      m_frame = {m_frame[30:0], m_mosi};
      m_bits++;
      if (m_bits <= 2) m_rise_t[m_bits-1] = $time;
      if (m_bits == 24) begin
        m_op   = m_frame[23:16];
        m_addr = m_frame[15:0];
        m_rd   = mem[m_addr];
      end
      if (m_bits == 32 && m_op == 8'h02) mem[m_addr] = m_frame[7:0];
    end
  end

  always @(negedge m_sclk) begin
    if (!m_cs_n && m_bits >= 24 && m_bits < 32) m_miso = m_rd[31-m_bits];
  end

  always @(posedge m_cs_n) begin
    m_last_bits  = m_bits;
    m_last_frame = m_frame;
    m_miso       = 1'b0;
  end

  // Scoreboard of expected responses.
  typedef struct packed {
    int unsigned due;
    logic        we;
    logic [7:0]  rdata;
    logic        div3;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  always @(negedge clk) begin
    if (rsp_valid1 || rsp_valid3) begin
      if (sb_q.size() == 0) begin
        check_eq("rsp_spurious", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check_eq("rsp_cycle", cyc, sb_e.due);
        check_eq("rsp_src", {31'd0, rsp_valid3}, {31'd0, sb_e.div3});
        if (!sb_e.we) check_eq("rsp_rdata", {24'd0, sb_e.div3 ? rdata3 : rdata1},
                               {24'd0, sb_e.rdata});
      end
    end
  end

  // Protocol watchers, checked once at the end.
  logic        sclk_bad = 1'b0;
  logic        ready_bad = 1'b0;
  int unsigned cs_run = 0;
  int unsigned min_gap = 1000;

  always @(negedge clk) begin
    if (!reset) begin
      if ((sclk1 && cs1) || (sclk3 && cs3)) sclk_bad = 1'b1;
      if ((!cs1 && ready1) || (!cs3 && ready3)) ready_bad = 1'b1;
      if ((busy1 != !ready1) || (busy3 != !ready3)) ready_bad = 1'b1;
      if (cs1) begin
        cs_run++;
      end else begin
        if (cs_run > 0 && cs_run < min_gap) min_gap = cs_run;
        cs_run = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic div3, input logic we, input logic [15:0] addr,
                       input logic [7:0] wd, input logic [7:0] exp_rd, input logic push,
                       input logic hold, output int unsigned acc);
    int unsigned n;
    n          = 0;
    sel3       = div3;
    req_valid1 = !div3;
    req_valid3 = div3;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wd;
    while (!(div3 ? ready3 : ready1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check_eq("accept_timeout", 32'd1, 32'd0);
    acc = cyc + 1;
    if (push) sb_q.push_back('{due: acc + 1 + 64 * (div3 ? 3 : 1), we: we, rdata: exp_rd,
                               div3: div3});
    @(negedge clk);
    if (!hold) begin
      req_valid1 = 1'b0;
      req_valid3 = 1'b0;
    end
    req_addr  = 16'hDEAD;
    req_wdata = 8'hEE;
    req_we    = ~we;
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check_eq("rsp_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  int unsigned acc_a, acc_b, n_wait;

  initial begin
    reset      = 1'b1;
    req_valid1 = 1'b0;
    req_valid3 = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    sel3       = 1'b0;
    mem[16'h0000] = 8'h77;
    mem[16'h0034] = 8'h3C;
    mem[16'h0010] = 8'hC7;
    mem[16'h0040] = 8'h99;
    mem[16'h0100] = 8'h5A;

    #1;
    check_eq("rst_cs_n", {31'd0, cs1}, 32'd1);
    check_eq("rst_sclk", {31'd0, sclk1}, 32'd0);
    check_eq("rst_mosi", {31'd0, mosi1}, 32'd0);
    check_eq("rst_ready", {31'd0, ready1}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid1}, 32'd0);
    check_eq("rst_rdata", {24'd0, rdata1}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 check_eq("ready_at_release", {31'd0, ready1}, 32'd0);
    @(negedge clk);
    check_eq("ready_after_edge", {31'd0, ready1}, 32'd1);

    // Write 0x0012 <- 0xA5
    issue(1'b0, 1'b1, 16'h0012, 8'hA5, 8'h00, 1'b1, 1'b0, acc_a);
    wait_done();
    check_eq("wr_mem", {24'd0, mem[16'h0012]}, 32'h0000_00A5);
    check_eq("wr_frame", m_last_frame, 32'h0200_12A5);
    check_eq("wr_rises", m_last_bits, 32'd32);

    // Read preloaded 0x0034
    issue(1'b0, 1'b0, 16'h0034, 8'h00, 8'h3C, 1'b1, 1'b0, acc_a);
    wait_done();
    check_eq("rd_frame", m_last_frame, 32'h0300_3400);
    check_eq("rd_rises", m_last_bits, 32'd32);

    // Boundary address
    issue(1'b0, 1'b1, 16'hFFFF, 8'h81, 8'h00, 1'b1, 1'b0, acc_a);
    wait_done();
    check_eq("ffff_frame", m_last_frame, 32'h02FF_FF81);
    issue(1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h81, 1'b1, 1'b0, acc_a);
    wait_done();
    check_eq("mem0_untouched", {24'd0, mem[16'h0000]}, 32'h0000_0077);

    // Back-to-back with req_valid held
    issue(1'b0, 1'b0, 16'h0010, 8'h00, 8'hC7, 1'b1, 1'b1, acc_a);
    issue(1'b0, 1'b1, 16'h0011, 8'h6E, 8'h00, 1'b1, 1'b0, acc_b);
    check_eq("b2b_spacing", acc_b - acc_a, 32'd67);
    wait_done();
    check_eq("b2b_mem", {24'd0, mem[16'h0011]}, 32'h0000_006E);
    check_eq("cs_gap_min2", {31'd0, min_gap >= 2}, 32'd1);

    // Abort a write at bit 10, then read the untouched location
    issue(1'b0, 1'b1, 16'h0040, 8'h11, 8'h00, 1'b0, 1'b0, acc_a);
    n_wait = 0;
    while (m_bits != 10 && n_wait < 200) begin
      @(negedge clk);
      n_wait++;
    end
    check_eq("abort_reached_bit10", m_bits, 32'd10);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_cs_n", {31'd0, cs1}, 32'd1);
    check_eq("abort_sclk", {31'd0, sclk1}, 32'd0);
    check_eq("abort_ready", {31'd0, ready1}, 32'd0);
    @(negedge clk);
    check_eq("abort_no_rsp", {31'd0, rsp_valid1}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_ready_back", {31'd0, ready1}, 32'd1);
    issue(1'b0, 1'b0, 16'h0040, 8'h00, 8'h99, 1'b1, 1'b0, acc_a);
    wait_done();
    check_eq("abort_mem", {24'd0, mem[16'h0040]}, 32'h0000_0099);

    // CLK_DIV=3 instance
    issue(1'b1, 1'b0, 16'h0100, 8'h00, 8'h5A, 1'b1, 1'b0, acc_a);
    wait_done();
    check_eq("div3_period", 32'((m_rise_t[1] - m_rise_t[0]) / 10), 32'd6);
    check_eq("div3_frame", m_last_frame, 32'h0301_0000);
    check_eq("div3_rises", m_last_bits, 32'd32);

    check_eq("sclk_high_with_cs_high", {31'd0, sclk_bad}, 32'd0);
    check_eq("ready_or_busy_in_frame", {31'd0, ready_bad}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
